if_id_hazard_reg: RTL
=====================

Name: if_id_hazard_reg

Overview:
- IF/ID pipeline register plus front-end hazard control for the 5-stage word-addressed MIPS core.
- Captures the fetch stage's PC+1 and instruction each cycle and presents them to decode.
- Detects load-use and multiply/divide (HI/LO) hazards, holds fetch and the register via stall_if, and requests an ID/EX bubble.
- Flushes the fetched instruction when a branch/jump resolves taken.

Parameters:
- MDU_LAT, 4, cycles a mult/div occupies the MDU after its start pulse; legal range 1..15.
- NOP_WORD, 32'h0000_0000, instruction word inserted on flush or reset.

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  reset, asynchronous, active-low.
- pc_p1_in  input  32  PC+1 from fetch.
- ins_in  input  32  instruction from fetch.
- pcsrc  input  1  taken branch/jump resolved this cycle; same signal that steers fetch to the target.
- ex_memread  input  1  instruction now in EX is a load.
- ex_rt  input  5  destination register of the EX load.
- mdu_start  input  1  single-cycle pulse: EX issued mult/multu/div/divu this cycle.
- pc_p1_id  output  32  registered PC+1 for decode.
- ins_id  output  32  registered instruction for decode.
- valid_id  output  1  ins_id is a real, non-flushed instruction.
- rs_id  output  5  ins_id[25:21].
- rt_id  output  5  ins_id[20:16].
- stall_if  output  1  hold PC and this register (combinational).
- bubble_ex  output  1  load a NOP into ID/EX next edge (combinational).
- mdu_busy  output  1  MDU countdown nonzero.

Behaviour:
- Reset (async, rst_n=0):
  - pc_p1_id=0, ins_id=NOP_WORD, valid_id=0, MDU counter=0.
  - Combinational outputs therefore read 0.
- Load-use hazard (lu), combinational: ex_memread & valid_id & ex_rt!=0 & (ex_rt==rs_id | ex_rt==rt_id).
- HI/LO decode (hilo): ins_id[31:26]==0 and funct ins_id[5:0] in {0x10 mfhi, 0x12 mflo, 0x18, 0x19, 0x1A, 0x1B}.
- MDU hazard (md), combinational: mdu_busy & valid_id & hilo.
- MDU counter (4 bits):
  - mdu_start=1: counter <= MDU_LAT-1. This reloads even when the counter is already nonzero.
  - Otherwise, when nonzero: decrement by 1. Zero holds.
  - mdu_busy = (counter!=0). MDU_LAT=1 never sets busy.
- Control outputs:
  - stall_if = (lu | md) & ~pcsrc.
  - bubble_ex = lu | md | pcsrc.
- Register update each rising edge, priority order:
  1. pcsrc=1 (flush): ins_id<=NOP_WORD, valid_id<=0, pc_p1_id<=pc_p1_in. Flush overrides any concurrent stall.
  2. stall_if=1: hold all three registers.
  3. Else: pc_p1_id<=pc_p1_in, ins_id<=ins_in, valid_id<=1.
- The MDU counter is not affected by flush or stall; it is an EX-side resource.
- rs_id and rt_id are pure slices of ins_id; a flushed entry yields 0 and therefore no hazard.
- Latency: one cycle from fetch output to decode output. A load-use stall lasts exactly 1 cycle, because the bubble removes the load from EX.
- An MDU stall persists until the counter reaches 0. An mfhi arriving with counter=k stalls k cycles.
- Reset mid-stall or mid-countdown clears immediately. The first edge after release loads from fetch normally.
- ex_rt=0 never stalls; a load to $zero is harmless.

Test Plan:
- Reset, then 3 sequential fetches (pc_p1_in=1,2,3; ins=0x8C010000, 0x00000020, 0x00221820), no hazards -> ins_id and pc_p1_id follow one cycle later; valid_id=1; stall_if=0 throughout.
- ins_id=add $3,$1,$2 (0x00221820) with ex_memread=1, ex_rt=1 -> stall_if=1 and bubble_ex=1 for exactly one cycle; ins_id held; it advances the next cycle once ex_memread=0. Repeat with ex_rt=0 -> no stall.
- MDU_LAT=4: mdu_start pulse, then mflo (0x00001012) arrives in ID the next cycle with counter=3 -> stall_if high 3 cycles; mdu_busy falls together with stall_if; mflo then advances.
- Load-use condition and pcsrc=1 in the same cycle -> stall_if=0, bubble_ex=1; next edge gives ins_id=0, valid_id=0 and pc_p1_id equal to that cycle's pc_p1_in.
- Second mdu_start while counter=2 (MDU_LAT=4) -> counter reloads to 3; mdu_busy stays high 3 more cycles.
- Assert rst_n=0 mid-MDU stall (counter=2) -> mdu_busy, stall_if and valid_id drop asynchronously; ins_id=0 before the next clock edge.

Source files
------------

// File: rtl/if_id_hazard_reg.sv
// IF/ID pipeline register with front-end hazard control: load-use and HI/LO-vs-MDU
// stalls, ID/EX bubble requests and flush of the fetched instruction on a taken branch.
module if_id_hazard_reg #(
    parameter int unsigned MDU_LAT  = 4,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_p1_in,
    input  logic [31:0] ins_in,
    input  logic        pcsrc,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rt,
    input  logic        mdu_start,
    output logic [31:0] pc_p1_id,
    output logic [31:0] ins_id,
    output logic        valid_id,
    output logic [4:0]  rs_id,
    output logic [4:0]  rt_id,
    output logic        stall_if,
    output logic        bubble_ex,
    output logic        mdu_busy
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] MDU_RELOAD = CNT_W'(MDU_LAT - 1);

    logic [CNT_W-1:0] mdu_cnt;
    logic             lu;
    logic             md;
    logic             hilo;

    assign rs_id    = ins_id[25:21];
    assign rt_id    = ins_id[20:16];
    assign mdu_busy = (mdu_cnt != '0);

    // Decoded instruction reads or writes HI/LO and must wait for the MDU
    always_comb begin
        hilo = 1'b0;
        if (ins_id[31:26] == 6'd0) begin
            case (ins_id[5:0])
                6'h10, 6'h12, 6'h18, 6'h19, 6'h1a, 6'h1b: hilo = 1'b1;
                default:                                  hilo = 1'b0;
            endcase
        end
    end

    assign lu = ex_memread & valid_id & (ex_rt != 5'd0) &
                ((ex_rt == rs_id) | (ex_rt == rt_id));
    assign md = mdu_busy & valid_id & hilo;

    // A taken branch discards the decode slot, so it never needs to be held
    assign stall_if  = (lu | md) & ~pcsrc;
    assign bubble_ex = lu | md | pcsrc;

    // MDU occupancy countdown; an EX-side resource untouched by flush or stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdu_cnt <= '0;
        end else if (mdu_start) begin
            mdu_cnt <= MDU_RELOAD;
        end else if (mdu_cnt != '0) begin
            mdu_cnt <= mdu_cnt - CNT_W'(1);
        end
    end

    // IF/ID register: flush beats stall beats normal capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_p1_id <= '0;
            ins_id   <= NOP_WORD;
            valid_id <= 1'b0;
        end else if (pcsrc) begin
            pc_p1_id <= pc_p1_in;
            ins_id   <= NOP_WORD;
            valid_id <= 1'b0;
        end else if (!stall_if) begin
            pc_p1_id <= pc_p1_in;
            ins_id   <= ins_in;
            valid_id <= 1'b1;
        end
    end

endmodule
